// File: rtl/frame_serializer.sv
// Buffered parallel-to-serial framer: words enter through a small FIFO and leave
// as start bit, DATA_W data bits, optional parity bit and stop bit, one bit per clock.
module frame_serializer #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int PAR_EN    = 1,
    parameter int PAR_ODD   = 0,
    parameter int MSB_FIRST = 0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [DATA_W-1:0]          IN_DATA,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    output logic                       SER_OUT,
    output logic                       BUSY,
    output logic                       FRAME_DONE,
    output logic [$clog2(DEPTH+1)-1:0] COUNT
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam bit PARITY_ON = (PAR_EN != 0);
    localparam bit ODD_BIT   = (PAR_ODD != 0);
    localparam bit MSB_MODE  = (MSB_FIRST != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              push;
    logic              pop;

    state_t            state;
    state_t            state_n;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_n;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  bit_cnt_n;
    logic              par_acc;
    logic              par_acc_n;
    logic              ser_q;
    logic              ser_n;
    logic              busy_q;
    logic              busy_n;
    logic              done_q;
    logic              done_n;
    logic              cur_bit;
    logic              fifo_has_data;

    // Readiness comes from the registered occupancy, so a full FIFO refuses a
    // word even on an edge where the serializer pops.
    assign IN_READY      = (count_q != CNT_W'(DEPTH));
    assign push          = IN_VALID && IN_READY;
    assign fifo_has_data = (count_q != '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= IN_DATA;
        end
    end

    assign cur_bit = MSB_MODE ? shift_q[DATA_W-1] : shift_q[0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            shift_q <= '0;
            bit_cnt <= '0;
            par_acc <= 1'b0;
            ser_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            shift_q <= shift_n;
            bit_cnt <= bit_cnt_n;
            par_acc <= par_acc_n;
            ser_q   <= ser_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    // The registered outputs carry the bit of the state being entered, so the
    // line always shows what the state register names.
    always_comb begin
        state_n   = state;
        shift_n   = shift_q;
        bit_cnt_n = bit_cnt;
        par_acc_n = par_acc;
        ser_n     = ser_q;
        busy_n    = busy_q;
        done_n    = 1'b0;
        pop       = 1'b0;

        case (state)
            IDLE: begin
                ser_n  = 1'b1;
                busy_n = 1'b0;
                if (fifo_has_data) begin
                    pop       = 1'b1;
                    shift_n   = mem[rd_ptr];
                    bit_cnt_n = '0;
                    par_acc_n = 1'b0;
                    state_n   = START;
                    ser_n     = 1'b0;
                    busy_n    = 1'b1;
                end
            end

            START, DATA: begin
                busy_n = 1'b1;
                if (state == DATA && bit_cnt == BIT_W'(DATA_W)) begin
                    if (PARITY_ON) begin
                        state_n = PARITY;
                        ser_n   = par_acc ^ ODD_BIT;
                    end else begin
                        state_n = STOP;
                        ser_n   = 1'b1;
                        done_n  = 1'b1;
                    end
                end else begin
                    state_n   = DATA;
                    ser_n     = cur_bit;
                    par_acc_n = par_acc ^ cur_bit;
                    bit_cnt_n = bit_cnt + 1'b1;
                    shift_n   = MSB_MODE ? (shift_q << 1) : (shift_q >> 1);
                end
            end

            PARITY: begin
                busy_n  = 1'b1;
                state_n = STOP;
                ser_n   = 1'b1;
                done_n  = 1'b1;
            end

            STOP: begin
                if (fifo_has_data) begin
                    pop       = 1'b1;
                    shift_n   = mem[rd_ptr];
                    bit_cnt_n = '0;
                    par_acc_n = 1'b0;
                    state_n   = START;
                    ser_n     = 1'b0;
                    busy_n    = 1'b1;
                end else begin
                    state_n = IDLE;
                    ser_n   = 1'b1;
                    busy_n  = 1'b0;
                end
            end

            default: begin
                state_n = IDLE;
                ser_n   = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign SER_OUT    = ser_q;
    assign BUSY       = busy_q;
    assign FRAME_DONE = done_q;
    assign COUNT      = count_q;

endmodule
